// File: rtl/div_seq.sv
// div_seq: sequencer between the execute-stage decoder and the iterative
// divider. Accepts RV32M DIV/DIVU/REM/REMU requests. Divide-by-zero and
// signed overflow are answered locally; every other request launches the
// divider. Operands are held stable while the divider runs, the pipeline
// is stalled while waiting, and the result comes back as a one-cycle
// writeback strobe with its destination register.
//
// Parameters:
//   D_WIDTH      operand/result width (only 32 supported)
//   GUARD_CYCLES launch-block window after reset (>= divider worst case)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_in            EX stage holds a divide-class op
//   funct3              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_val, rs2_val    dividend, divisor
//   rd_addr             destination register
//   flush               squash the in-flight op
//   stall               hold EX and upstream stages
//   wb_valid            one-cycle result strobe
//   wb_data, wb_rd      result and its destination register
//   div_start           divider start pulse
//   div_ctrl            funct3[1:0], held from launch until div_done
//   div_num, div_den    operands, held from launch until div_done
//   div_result          divider result
//   div_done            divider completion pulse
//
// Optional feature: define DIV_RESULT_CACHE_EN to add a one-entry cache of
// the last divider-computed result, tagged by {funct3, rs1_val, rs2_val}.
module div_seq #(
    parameter int D_WIDTH      = 32,
    parameter int GUARD_CYCLES = 36
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] rs1_val,
    input  logic [D_WIDTH-1:0] rs2_val,
    input  logic [4:0]         rd_addr,
    input  logic               flush,
    output logic               stall,
    output logic               wb_valid,
    output logic [D_WIDTH-1:0] wb_data,
    output logic [4:0]         wb_rd,
    output logic               div_start,
    output logic [1:0]         div_ctrl,
    output logic [D_WIDTH-1:0] div_num,
    output logic [D_WIDTH-1:0] div_den,
    input  logic [D_WIDTH-1:0] div_result,
    input  logic               div_done
);

    localparam int                 CNT_W      = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [D_WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [D_WIDTH-1:0] MOST_NEG   = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        GUARD,
        IDLE,
        LAUNCH,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   guard_cnt;
    logic               accept;
    logic               is_zero_div;
    logic               is_overflow;
    logic               cache_hit;
    logic               fast_path;
    logic [D_WIDTH-1:0] special_data;
    logic [D_WIDTH-1:0] fast_data;
    logic               wait_done;

    assign accept      = (state == IDLE) && valid_in && !flush;
    assign is_zero_div = (rs2_val == '0);
    // Only the signed ops (funct3[0] == 0) can overflow.
    assign is_overflow = !funct3[0] && (rs1_val == MOST_NEG) && (rs2_val == ALL_ONES);
    assign fast_path   = is_zero_div || is_overflow || cache_hit;
    // A flush in the same cycle as div_done wins: the result is discarded.
    assign wait_done   = (state == WAIT) && div_done && !flush;

    // RISC-V defined results for the two special cases; funct3[1] selects REM.
    always_comb begin
        special_data = '0;
        if (is_zero_div) begin
            special_data = funct3[1] ? rs1_val : ALL_ONES;
        end else begin
            special_data = funct3[1] ? '0 : MOST_NEG;
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    logic [2:0]             op_funct3;
    logic                   cache_valid;
    logic [2*D_WIDTH+2:0]   cache_tag;
    logic [D_WIDTH-1:0]     cache_data;

    assign cache_hit = cache_valid && (cache_tag == {funct3, rs1_val, rs2_val});
    assign fast_data = (is_zero_div || is_overflow) ? special_data : cache_data;

    // The cache only learns divider-computed results; flushed runs and
    // locally answered ops never fill it, and only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_funct3   <= '0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else begin
            if (accept && !fast_path) begin
                op_funct3 <= funct3;
            end
            if (wait_done) begin
                cache_valid <= 1'b1;
                cache_tag   <= {op_funct3, div_num, div_den};
                cache_data  <= div_result;
            end
        end
    end
`else
    logic unused_funct3_msb;

    assign cache_hit         = 1'b0;
    assign fast_data         = special_data;
    assign unused_funct3_msb = funct3[2];
`endif

    // State register and the post-reset guard counter. The divider has no
    // reset of its own, so launches are blocked until it has surely drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GUARD;
            guard_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state == GUARD) && (guard_cnt != GUARD_LAST)) begin
                guard_cnt <= guard_cnt + CNT_W'(1);
            end else begin
                guard_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            GUARD:  if (guard_cnt == GUARD_LAST) state_next = IDLE;
            IDLE:   if (accept) state_next = fast_path ? RESP : LAUNCH;
            LAUNCH: state_next = flush ? DRAIN : WAIT;
            WAIT: begin
                if (flush) begin
                    state_next = div_done ? IDLE : DRAIN;
                end else if (div_done) begin
                    state_next = RESP;
                end
            end
            RESP:   state_next = IDLE;
            DRAIN:  if (div_done) state_next = IDLE;
            default: state_next = GUARD;
        endcase
    end

    // Divider operands only move on entry to LAUNCH so they stay stable for
    // the whole divider run; the result register takes either the local
    // answer or the divider's output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data  <= '0;
            wb_rd    <= '0;
            div_ctrl <= '0;
            div_num  <= '0;
            div_den  <= '0;
        end else begin
            if (accept) begin
                wb_rd <= rd_addr;
                if (fast_path) begin
                    wb_data <= fast_data;
                end else begin
                    div_ctrl <= funct3[1:0];
                    div_num  <= rs1_val;
                    div_den  <= rs2_val;
                end
            end
            if (wait_done) begin
                wb_data <= div_result;
            end
        end
    end

    // Stall is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        stall     = 1'b0;
        wb_valid  = 1'b0;
        div_start = 1'b0;
        if (rst_n) begin
            stall = valid_in && ((!flush && (state != RESP))
                                 || (state == GUARD) || (state == DRAIN));
        end
        wb_valid  = (state == RESP) && !flush;
        div_start = (state == LAUNCH);
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequencer between the execute-stage decoder and the iterative `div` unit. It accepts RV32M DIV/DIVU/REM/REMU requests, resolves the divide-by-zero and signed-overflow cases itself, and launches the divider for every other request. It holds operands stable for the divider's full run, stalls the pipeline while it waits, and returns a single-cycle writeback pulse carrying the result and destination register.

## Interface
- `D_WIDTH`, 32, operand/result width (only 32 supported)
- `GUARD_CYCLES`, 36, launch-block window after reset (≥ divider worst-case occupancy)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `valid_in`  in  1  EX stage holds a divide-class op
- `funct3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_val`, `rs2_val`  in  D_WIDTH  dividend, divisor
- `rd_addr`  in  5  destination register
- `flush`  in  1  squash in-flight op
- `stall`  out  1  hold EX and upstream stages
- `wb_valid`  out  1  one-cycle result strobe
- `wb_data`  out  D_WIDTH  result
- `wb_rd`  out  5  destination for `wb_data`
- `div_start`  out  1  divider start, one-cycle pulse
- `div_ctrl`  out  2  `funct3[1:0]`, held from launch until `div_done`
- `div_num`, `div_den`  out  D_WIDTH  held from launch until `div_done`
- `div_result`  in  D_WIDTH  divider result
- `div_done`  in  1  divider completion pulse

## Operation
- FSM states: GUARD, IDLE, LAUNCH, WAIT, RESP, DRAIN. Reset enters GUARD.
- GUARD: counter runs 0 → GUARD_CYCLES-1, then IDLE. The divider has no reset, so this window lets it return to idle. Requests are not accepted in GUARD.
- IDLE, `valid_in && !flush`: latch `funct3`, operands and `rd_addr`.
  - Fast path → RESP:
    - `rs2_val==0`: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `rs1_val`.
    - Signed op with `rs1_val==0x80000000 && rs2_val==0xFFFFFFFF`: DIV returns 0x80000000; REM returns 0.
  - Otherwise → LAUNCH.
- LAUNCH: `div_start=1` for one cycle → WAIT.
- WAIT: on `div_done`, capture `div_result` → RESP.
- RESP: `wb_valid=1` for one cycle with the latched `wb_rd` → IDLE.
- `flush` in LAUNCH or WAIT → DRAIN. DRAIN waits for `div_done`, discards the result, then → IDLE. No `wb_valid` is raised.
- `flush` in RESP suppresses `wb_valid`.
- `stall = valid_in && !flush && state != RESP`, plus forced high in GUARD/DRAIN when `valid_in` is set.
  - `stall` is low in the `wb_valid` cycle.
  - `stall` is low while `valid_in` is low.
- Reset values: all outputs 0, FSM in GUARD, counter 0, cache invalid. Reset mid-WAIT abandons the op; no writeback follows.

## Timing
- Accept in cycle A (IDLE, `valid_in`).
- `div_start` is high in cycle A+1.
- Divider: INIT at A+2, DIVIDE A+3..A+34, DONE A+35. `div_done` and `div_result` are visible at A+36.
- `wb_valid` is high at A+37. `stall` is high for A..A+36.
- Fast path: `wb_valid` at A+1; `stall` is high only in A.
- Back-to-back requests: the next accept is possible in the cycle after RESP.
- `div_ctrl`, `div_num` and `div_den` change only on a LAUNCH entry.
- `div_done` outside WAIT/DRAIN is ignored.

## Configuration
- `DIV_RESULT_CACHE_EN` defined:
  - One-entry cache tagged by {`funct3`, `rs1_val`, `rs2_val`}, holding the last divider-computed result.
  - A hit in IDLE takes the fast path: RESP next cycle, no launch.
  - Filled on the WAIT→RESP transition. Not filled from DRAIN or from fast-path results.
  - Invalidated only by reset.
- Undefined: no cache storage. Every non-special op launches the divider.

## Test plan
- Reset, then `valid_in` with DIV 100/7 at cycle 2: `stall` held, no `div_start` until GUARD expires; result `wb_data`=14.
- After GUARD: DIV -20/3 accepted at A → `div_start` at A+1, `wb_valid` at A+37 with `wb_data`=0xFFFFFFFA. REM of the same operands gives 0xFFFFFFFE.
- DIVU 5/0 → `wb_valid` at A+1 with 0xFFFFFFFF, no `div_start`. REM 0x80000000/0xFFFFFFFF → 0 at A+1.
- DIVU 0xFFFFFFFF/16 with `flush` at A+10: `stall` drops, no `wb_valid`. A new REMU 9/4 stalls until `div_done`, then returns 1.
- With `DIV_RESULT_CACHE_EN`: DIVU 1000/9 twice. The first gives 111 at A+37; the second gives 111 at A'+1 with no `div_start`.
- Assert `rst_n` low during WAIT: all outputs are 0 immediately. GUARD then runs the full 36 cycles and no stale `wb_valid` appears.
